// File: rtl/iommu_hpm_ctrl.sv
// IOMMU performance counters: round-robin event intake, one staging register, N_CNT counters, OF/IRQ.
// Count is visible 2 cycles after the accepting handshake; one event is accepted per cycle, none during reset.
module iommu_hpm_ctrl #(
  parameter int N_SRC = 4,
  parameter int N_CNT = 4,
  parameter int CNT_W = 64,
  parameter int EVT_W = 15
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [N_SRC-1:0]                 evt_valid_i,
  input  logic [N_SRC-1:0][EVT_W-1:0]      evt_id_i,
  output logic [N_SRC-1:0]                 evt_ready_o,
  input  logic [N_CNT-1:0][EVT_W-1:0]      evt_sel_i,
  input  logic [N_CNT-1:0]                 inh_i,
  input  logic [N_CNT-1:0]                 wr_en_i,
  input  logic [CNT_W-1:0]                 wr_data_i,
  input  logic [N_CNT-1:0]                 ovf_clr_i,
  input  logic                             irq_ack_i,
  output logic [N_CNT-1:0][CNT_W-1:0]      cnt_o,
  output logic [N_CNT-1:0]                 ovf_o,
  output logic                             irq_o
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {IRQ_IDLE, IRQ_PEND} irq_state_e;

  logic [PW-1:0]                 rr_ptr_q, rr_ptr_d;
  logic                          arb_en_q, arb_en_d;
  logic                          stage_vld_q, stage_vld_d;
  logic [EVT_W-1:0]              stage_id_q, stage_id_d;
  logic [N_CNT-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_CNT-1:0]              ovf_q, ovf_d;
  irq_state_e                    state_q, state_d;

  logic [N_SRC-1:0]              grant;
  logic                          grant_any;
  logic [PW-1:0]                 grant_idx;
  logic [N_CNT-1:0]              hit;
  logic [N_CNT-1:0]              wrap;
  logic                          new_ovf;

  // Modulo-N_SRC add; both operands are always below N_SRC.
  function automatic logic [PW-1:0] src_add(input logic [PW-1:0] base, input logic [PW-1:0] off);
    logic [PW:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (PW+1)'(N_SRC)) sum = sum - (PW+1)'(N_SRC);
    return sum[PW-1:0];
  endfunction

  // Arbitration is held off until the first edge after reset so evt_ready_o stays low throughout reset.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = rr_ptr_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (!grant_any && arb_en_q && evt_valid_i[src_add(rr_ptr_q, PW'(i))]) begin
        grant_any = 1'b1;
        grant_idx = src_add(rr_ptr_q, PW'(i));
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    arb_en_d    = 1'b1;
    rr_ptr_d    = grant_any ? src_add(grant_idx, PW'(1)) : rr_ptr_q;
    stage_vld_d = grant_any;
    stage_id_d  = grant_any ? evt_id_i[grant_idx] : stage_id_q;
  end

  // Software write beats a same-cycle increment; a fresh wrap beats a same-cycle OF clear.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    hit   = '0;
    wrap  = '0;
    for (int c = 0; c < N_CNT; c++) begin
      hit[c] = stage_vld_q && (stage_id_q != '0) && (evt_sel_i[c] == stage_id_q) && !inh_i[c];
      if (wr_en_i[c]) begin
        cnt_d[c] = wr_data_i;
      end else if (hit[c]) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
        wrap[c]  = &cnt_q[c];
      end
      if (wrap[c]) begin
        ovf_d[c] = 1'b1;
      end else if (ovf_clr_i[c]) begin
        ovf_d[c] = 1'b0;
      end
    end
  end

  assign new_ovf = |(wrap & ~ovf_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IRQ_IDLE: if (new_ovf) state_d = IRQ_PEND;
      IRQ_PEND: if (irq_ack_i && !new_ovf) state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      arb_en_q    <= 1'b0;
      stage_vld_q <= 1'b0;
      stage_id_q  <= '0;
      cnt_q       <= '0;
      ovf_q       <= '0;
      state_q     <= IRQ_IDLE;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      arb_en_q    <= arb_en_d;
      stage_vld_q <= stage_vld_d;
      stage_id_q  <= stage_id_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
    end
  end

  assign evt_ready_o = grant;
  assign cnt_o       = cnt_q;
  assign ovf_o       = ovf_q;
  assign irq_o       = (state_q == IRQ_PEND);

endmodule

// File: tb/tb_iommu_hpm_ctrl.sv
// Directed table of per-cycle inputs and expected outputs, then a reset-during-staged-event sequence.
module tb_iommu_hpm_ctrl;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic [3:0]         evt_valid_i;
  logic [3:0][14:0]   evt_id_i;
  logic [3:0]         evt_ready_o;
  logic [3:0][14:0]   evt_sel_i;
  logic [3:0]         inh_i;
  logic [3:0]         wr_en_i;
  logic [63:0]        wr_data_i;
  logic [3:0]         ovf_clr_i;
  logic               irq_ack_i;
  logic [3:0][63:0]   cnt_o;
  logic [3:0]         ovf_o;
  logic               irq_o;

  iommu_hpm_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .evt_valid_i(evt_valid_i), .evt_id_i(evt_id_i), .evt_ready_o(evt_ready_o),
    .evt_sel_i(evt_sel_i), .inh_i(inh_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .ovf_clr_i(ovf_clr_i), .irq_ack_i(irq_ack_i),
    .cnt_o(cnt_o), .ovf_o(ovf_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  vld;
    logic [14:0] id;
    logic [14:0] sel0;
    logic [3:0]  inh;
    logic [3:0]  wr;
    logic [63:0] wdat;
    logic [3:0]  clr;
    logic        ack;
    logic [3:0]  e_rdy;
    logic [63:0] e_c0, e_c1, e_c2, e_c3;
    logic [3:0]  e_ovf;
    logic        e_irq;
  } vec_t;

  vec_t tbl[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic add(input int vld, input int id, input int sel0, input int inh, input int wr,
                     input logic [63:0] wdat, input int clr, input int ack, input int rdy,
                     input logic [63:0] c0, input logic [63:0] c1, input logic [63:0] c2,
                     input logic [63:0] c3, input int ovf, input int irq);
    vec_t v;
    v.vld = 4'(vld); v.id = 15'(id); v.sel0 = 15'(sel0); v.inh = 4'(inh); v.wr = 4'(wr);
    v.wdat = wdat; v.clr = 4'(clr); v.ack = 1'(ack); v.e_rdy = 4'(rdy);
    v.e_c0 = c0; v.e_c1 = c1; v.e_c2 = c2; v.e_c3 = c3; v.e_ovf = 4'(ovf); v.e_irq = 1'(irq);
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int step, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s step %0d: got %0h, want %0h", nm, step, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    evt_valid_i = v.vld;
    for (int s = 0; s < 4; s++) evt_id_i[s] = v.id;
    evt_sel_i[0] = v.sel0;
    evt_sel_i[1] = 15'd2;
    evt_sel_i[2] = 15'd3;
    evt_sel_i[3] = 15'd1;
    inh_i = v.inh; wr_en_i = v.wr; wr_data_i = v.wdat; ovf_clr_i = v.clr; irq_ack_i = v.ack;
  endtask

  task automatic check_vec(input int step, input vec_t v);
    n_vec++;
    chk("rdy", step, 64'(evt_ready_o), 64'(v.e_rdy));
    chk("cnt0", step, cnt_o[0], v.e_c0);
    chk("cnt1", step, cnt_o[1], v.e_c1);
    chk("cnt2", step, cnt_o[2], v.e_c2);
    chk("cnt3", step, cnt_o[3], v.e_c3);
    chk("ovf", step, 64'(ovf_o), 64'(v.e_ovf));
    chk("irq", step, 64'(irq_o), 64'(v.e_irq));
  endtask

  initial begin
    vec_t idle;
    //  vld id sel inh wr wdat clr ack | rdy c0 c1 c2 c3 ovf irq
    add( 0, 0, 1, 0, 0, 0,    0, 0,   0, 0, 0, 0, 0, 0, 0);
    add(15, 1, 1, 0, 0, 0,    0, 0,   1, 0, 0, 0, 0, 0, 0);
    add(15, 1, 1, 0, 0, 0,    0, 0,   2, 0, 0, 0, 0, 0, 0);
    add(15, 1, 1, 0, 0, 0,    0, 0,   4, 1, 0, 0, 1, 0, 0);
    add(15, 1, 1, 0, 0, 0,    0, 0,   8, 2, 0, 0, 2, 0, 0);
    add(15, 1, 1, 0, 0, 0,    0, 0,   1, 3, 0, 0, 3, 0, 0);
    add(15, 1, 1, 0, 0, 0,    0, 0,   2, 4, 0, 0, 4, 0, 0);
    add(15, 1, 1, 0, 0, 0,    0, 0,   4, 5, 0, 0, 5, 0, 0);
    add(15, 1, 1, 0, 0, 0,    0, 0,   8, 6, 0, 0, 6, 0, 0);
    add( 0, 0, 1, 0, 0, 0,    0, 0,   0, 7, 0, 0, 7, 0, 0);
    add( 0, 0, 1, 0, 0, 0,    0, 0,   0, 8, 0, 0, 8, 0, 0);
    add( 4, 2, 1, 0, 0, 0,    0, 0,   4, 8, 0, 0, 8, 0, 0);
    add( 3, 0, 1, 0, 0, 0,    0, 0,   1, 8, 0, 0, 8, 0, 0);
    add( 0, 0, 0, 0, 0, 0,    0, 0,   0, 8, 1, 0, 8, 0, 0);
    add(15, 1, 1, 1, 0, 0,    0, 0,   2, 8, 1, 0, 8, 0, 0);
    add( 0, 0, 1, 1, 0, 0,    0, 0,   0, 8, 1, 0, 8, 0, 0);
    add( 0, 0, 1, 0, 0, 0,    0, 0,   0, 8, 1, 0, 9, 0, 0);
    add( 1, 1, 1, 0, 0, 0,    0, 0,   1, 8, 1, 0, 9, 0, 0);
    add( 0, 0, 3, 0, 0, 0,    0, 0,   0, 8, 1, 0, 9, 0, 0);
    add( 0, 0, 1, 0, 0, 0,    0, 0,   0, 8, 1, 0,10, 0, 0);
    add( 1, 3, 1, 0, 0, 0,    0, 0,   1, 8, 1, 0,10, 0, 0);
    add( 0, 0, 1, 0, 4, 5,    0, 0,   0, 8, 1, 0,10, 0, 0);
    add( 1, 3, 1, 0, 0, 0,    0, 0,   1, 8, 1, 5,10, 0, 0);
    add( 0, 0, 1, 0, 0, 0,    0, 0,   0, 8, 1, 5,10, 0, 0);
    add( 0, 0, 1, 0, 0, 0,    0, 0,   0, 8, 1, 6,10, 0, 0);
    add( 0, 0, 1, 0, 2, ONES, 0, 0,   0, 8, 1, 6,10, 0, 0);
    add( 1, 2, 1, 0, 0, 0,    0, 0,   1, 8, ONES, 6,10, 0, 0);
    add( 0, 0, 1, 0, 0, 0,    0, 0,   0, 8, ONES, 6,10, 0, 0);
    add( 0, 0, 1, 0, 0, 0,    0, 0,   0, 8, 0, 6,10, 2, 1);
    add( 0, 0, 1, 0, 0, 0,    0, 0,   0, 8, 0, 6,10, 2, 1);
    add( 0, 0, 1, 0, 0, 0,    0, 1,   0, 8, 0, 6,10, 2, 1);
    add( 0, 0, 1, 0, 0, 0,    0, 0,   0, 8, 0, 6,10, 2, 0);
    add( 0, 0, 1, 0, 2, ONES, 0, 0,   0, 8, 0, 6,10, 2, 0);
    add( 1, 2, 1, 0, 0, 0,    0, 0,   1, 8, ONES, 6,10, 2, 0);
    add( 0, 0, 1, 0, 0, 0,    2, 0,   0, 8, ONES, 6,10, 2, 0);
    add( 0, 0, 1, 0, 0, 0,    0, 0,   0, 8, 0, 6,10, 2, 0);
    add( 0, 0, 1, 0, 0, 0,    2, 0,   0, 8, 0, 6,10, 2, 0);
    add( 0, 0, 1, 0, 0, 0,    0, 0,   0, 8, 0, 6,10, 0, 0);
    add( 0, 0, 1, 0, 6, ONES, 0, 0,   0, 8, 0, 6,10, 0, 0);
    add( 1, 2, 1, 0, 0, 0,    0, 0,   1, 8, ONES, ONES,10, 0, 0);
    add( 1, 3, 1, 0, 0, 0,    0, 0,   1, 8, ONES, ONES,10, 0, 0);
    add( 0, 0, 1, 0, 0, 0,    0, 1,   0, 8, 0, ONES,10, 2, 1);
    add( 0, 0, 1, 0, 0, 0,    0, 0,   0, 8, 0, 0,10, 6, 1);
    add( 0, 0, 1, 0, 0, 0,    0, 1,   0, 8, 0, 0,10, 6, 1);
    add( 0, 0, 1, 0, 0, 0,    0, 0,   0, 8, 0, 0,10, 6, 0);

    // Reset with all sources requesting: every output at its reset value.
    idle = tbl[0];
    idle.vld = 4'hF;
    idle.id  = 15'd1;
    drive(idle);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check_vec(-1, tbl[0]);
    evt_valid_i = 4'h0;
    rst_ni = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk_i);
      drive(tbl[k]);
      #1;
      check_vec(k, tbl[k]);
    end

    // Reset one cycle after a transfer: the staged event must be discarded.
    @(negedge clk_i);
    idle = tbl[0];
    idle.vld = 4'h1;
    idle.id  = 15'd1;
    drive(idle);
    #1;
    n_vec++;
    chk("pre_rst_rdy", 100, 64'(evt_ready_o), 64'h1);
    @(negedge clk_i);
    evt_valid_i = 4'hF;
    rst_ni = 1'b0;
    #1;
    check_vec(101, tbl[0]);
    @(negedge clk_i);
    evt_valid_i = 4'h0;
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    check_vec(102, tbl[0]);
    evt_valid_i = 4'hF;
    #1;
    n_vec++;
    chk("rr_ptr_after_rst", 103, 64'(evt_ready_o), 64'h1);
    @(negedge clk_i);
    evt_valid_i = 4'h0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/iommu_hpm_ctrl.md
IOMMU_HPM_CTRL -- requirements
Module: iommu_hpm_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 4: number of event requesters.
REQ-002 SHALL have parameter N_CNT, default 4: number of programmable counters.
REQ-003 SHALL have parameter CNT_W, default 64: counter width.
REQ-004 SHALL have parameter EVT_W, default 15: event ID width.
REQ-005 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port evt_valid_i, input, N_SRC: per-source event request.
REQ-008 SHALL have port evt_id_i, input, N_SRC x EVT_W: per-source event ID.
REQ-009 SHALL have port evt_ready_o, output, N_SRC: one-hot grant/accept.
REQ-010 SHALL have port evt_sel_i, input, N_CNT x EVT_W: per-counter programmed event ID.
REQ-011 SHALL have port inh_i, input, N_CNT: per-counter inhibit.
REQ-012 SHALL have port wr_en_i, input, N_CNT: software counter write strobe.
REQ-013 SHALL have port wr_data_i, input, CNT_W: software write data.
REQ-014 SHALL have port ovf_clr_i, input, N_CNT: per-counter overflow clear strobe.
REQ-015 SHALL have port irq_ack_i, input, 1: interrupt acknowledge.
REQ-016 SHALL have port cnt_o, output, N_CNT x CNT_W: counter values.
REQ-017 SHALL have port ovf_o, output, N_CNT: overflow (OF) status bits.
REQ-018 SHALL have port irq_o, output, 1: overflow interrupt request, level.

Function
REQ-019 Arbitration SHALL be round-robin: at most one evt_ready_o bit high per cycle, only for a source with evt_valid_i high; no grant when no source is valid.
REQ-020 The search for a grant SHALL start at the source after the last granted source; the pointer SHALL update only on a grant.
REQ-021 A transfer SHALL occur when evt_valid_i[k] and evt_ready_o[k] are both high; the granted evt_id SHALL be registered into a one-entry pipeline stage (stage valid + ID) in the same edge.
REQ-022 In the cycle after the transfer, each counter c with evt_sel_i[c] equal to the staged ID, evt_sel_i[c] nonzero and inh_i[c] low SHALL increment by 1 at that edge; the new value SHALL be visible on cnt_o two cycles after the transfer cycle.
REQ-023 A staged ID of 0 SHALL never increment any counter; one event MAY increment multiple counters.
REQ-024 Increment SHALL wrap from all-ones to 0 modulo 2^CNT_W; on wrap, ovf_o[c] SHALL be set.
REQ-025 wr_en_i[c] SHALL load wr_data_i into counter c at the next edge; a coincident increment of c SHALL be dropped (write wins) and SHALL NOT set ovf_o[c].
REQ-026 ovf_clr_i[c] SHALL clear ovf_o[c]; a coincident set SHALL win (ovf_o[c] stays 1).
REQ-027 Interrupt FSM SHALL have states IDLE and PEND; IDLE->PEND when any ovf_o bit transitions 0->1; PEND->IDLE on irq_ack_i; irq_o SHALL be high exactly in PEND.
REQ-028 A new 0->1 OF transition coincident with irq_ack_i in PEND SHALL keep the FSM in PEND.
REQ-029 A wrap on a counter whose ovf_o is already 1 SHALL NOT raise a new interrupt.
REQ-030 Changes to inh_i or evt_sel_i SHALL take effect for the staged event evaluated in the same cycle.

Reset
REQ-031 On rst_ni low, all counters SHALL be 0, ovf_o all 0, irq_o 0, FSM IDLE, evt_ready_o all 0, pipeline stage invalid, RR pointer at source 0 (so source 0 has highest priority first).
REQ-032 Reset asserted with an event staged SHALL discard that event; no counter changes after reset release without a new transfer.

Verification
REQ-033 All 4 sources valid continuously, evt_sel_i[0]=1, all sources ID 1 -> grants cycle 0,1,2,3,0...; cnt_o[0] reaches 8 after 8 grants plus 2 cycles.
REQ-034 Write cnt 1 = 0xFFFF_FFFF_FFFF_FFFF, event matching counter 1 -> cnt_o[1]=0, ovf_o[1]=1, irq_o=1 until irq_ack_i, then 0.
REQ-035 wr_en_i[2] with wr_data_i=5 in the same cycle as a matching increment -> cnt_o[2]=5, ovf_o[2] unchanged.
REQ-036 inh_i[0]=1 or evt_sel_i[0]=0 with ID-0 and matching events -> cnt_o[0] stays 0.
REQ-037 ovf_clr_i[1] coincident with counter-1 wrap -> ovf_o[1]=1; second wrap with ovf_o[1]=1 and FSM IDLE -> irq_o stays 0.
REQ-038 rst_ni pulsed low one cycle after a transfer -> all outputs at reset values, cnt_o stays 0 after release.
